// File: rtl/trackers_pkg.sv
// trackers_pkg
// Shared types and defaults for the test-progress tracker.
//   tracker_state_e     : FSM state encoding (IDLE=0, RUN=1, DONE=2, TIMEOUT=3)
//   DEFAULT_CYCLE_CNT_W : default width of every cycle count and timestamp
package trackers_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1,
    DONE    = 2'd2,
    TIMEOUT = 2'd3
  } tracker_state_e;

  localparam int DEFAULT_CYCLE_CNT_W = 32;

endpackage

// File: rtl/trackers_sat_counter.sv
// sat_counter
// Up-counter that sticks at all-ones instead of wrapping.
//   clk   : clock
//   rst   : asynchronous active-high reset, count -> 0
//   clear : synchronous clear, takes priority over inc
//   inc   : count up by one this cycle (ignored once saturated)
//   count : current count value
module sat_counter
  import trackers_pkg::*;
#(
  parameter int WIDTH = DEFAULT_CYCLE_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  // Clear wins over increment so a re-armed run always starts from zero,
  // and the all-ones check keeps the count pinned instead of wrapping to 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + ONE;
    end
  end

endmodule

// File: rtl/trackers.sv
// trackers
// Observe-only progress tracker for a test running on the core. A trigger
// pulse starts a run and timestamps it; the fall of test_undone ends it
// normally, or the run times out after TIMEOUT_CYCLES clocks.
//   clk, rst     : free-running clock, asynchronous active-high reset
//   trigger      : start pulse (ignored while a run is in progress)
//   test_undone  : high while the test runs, low when finished
//   enable       : core clock-gate enable, counted only
//   cycle_count  : core cycle counter sampled for the timestamps
//   busy         : high while in RUN
//   done         : sticky, run ended normally
//   done_pulse   : one-cycle strobe on entry to DONE
//   timeout      : sticky, run ended on timeout
//   start_stamp  : cycle_count at the start edge
//   end_stamp    : cycle_count at the end edge
//   run_cycles   : clocks spent in RUN (saturating)
//   gated_cycles : RUN clocks with enable low (saturating)
//   state        : current FSM state
module trackers
  import trackers_pkg::*;
#(
  parameter int CYCLE_CNT_W    = DEFAULT_CYCLE_CNT_W,
  parameter int TIMEOUT_CYCLES = 5000
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   trigger,
  input  logic                   test_undone,
  input  logic                   enable,
  input  logic [CYCLE_CNT_W-1:0] cycle_count,
  output logic                   busy,
  output logic                   done,
  output logic                   done_pulse,
  output logic                   timeout,
  output logic [CYCLE_CNT_W-1:0] start_stamp,
  output logic [CYCLE_CNT_W-1:0] end_stamp,
  output logic [CYCLE_CNT_W-1:0] run_cycles,
  output logic [CYCLE_CNT_W-1:0] gated_cycles,
  output logic [1:0]             state
);

  // One bit wider than the counters so the "next" run count never wraps
  // before it is compared against the timeout length.
  localparam logic [CYCLE_CNT_W:0] ONE_W     = (CYCLE_CNT_W+1)'(1);
  localparam logic [CYCLE_CNT_W:0] TIMEOUT_W = (CYCLE_CNT_W+1)'(TIMEOUT_CYCLES);

  tracker_state_e       state_q;
  logic                 first_cycle;
  logic                 in_run;
  logic                 start_run;
  logic                 run_inc;
  logic                 gated_inc;
  logic                 hit_done;
  logic                 hit_timeout;
  logic [CYCLE_CNT_W:0] run_next;

  // A trigger only starts a run from a non-RUN state; in RUN it is ignored.
  // The first RUN cycle never looks at test_undone, so every run is at least
  // two clocks long.
  assign in_run      = (state_q == RUN);
  assign start_run   = trigger && !in_run;
  assign run_inc     = in_run;
  assign gated_inc   = in_run && !enable;
  assign run_next    = {1'b0, run_cycles} + ONE_W;
  assign hit_done    = in_run && !first_cycle && !test_undone;
  assign hit_timeout = in_run && (run_next == TIMEOUT_W);

  assign busy  = in_run;
  assign state = state_q;

  sat_counter #(
    .WIDTH (CYCLE_CNT_W)
  ) u_run_ctr (
    .clk   (clk),
    .rst   (rst),
    .clear (start_run),
    .inc   (run_inc),
    .count (run_cycles)
  );

  sat_counter #(
    .WIDTH (CYCLE_CNT_W)
  ) u_gated_ctr (
    .clk   (clk),
    .rst   (rst),
    .clear (start_run),
    .inc   (gated_inc),
    .count (gated_cycles)
  );

  // Run-control FSM with its registered results. IDLE, DONE and TIMEOUT all
  // behave alike towards a trigger: re-arm straight into RUN and clear the
  // previous result. A normal finish is checked before the timeout so it
  // wins when both land on the same edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      first_cycle <= 1'b0;
      start_stamp <= '0;
      end_stamp   <= '0;
      done        <= 1'b0;
      done_pulse  <= 1'b0;
      timeout     <= 1'b0;
    end else begin
      done_pulse <= 1'b0;
      unique case (state_q)
        RUN: begin
          first_cycle <= 1'b0;
          if (hit_done) begin
            state_q    <= DONE;
            end_stamp  <= cycle_count;
            done       <= 1'b1;
            done_pulse <= 1'b1;
          end else if (hit_timeout) begin
            state_q   <= TIMEOUT;
            end_stamp <= cycle_count;
            timeout   <= 1'b1;
          end
        end
        default: begin
          if (trigger) begin
            state_q     <= RUN;
            first_cycle <= 1'b1;
            start_stamp <= cycle_count;
            end_stamp   <= '0;
            done        <= 1'b0;
            timeout     <= 1'b0;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_trackers.sv
// tb_trackers
// Randomized and directed bench for trackers. The stimulus side works out the
// expected result of each run from the run rules and queues it; a monitor
// pops and compares whenever the DUT reports the end of a run. A second,
// 8-bit instance is used to see the counters saturate.
module tb_trackers;

  localparam int T = 50;

  typedef struct {
    logic [31:0] start_s;
    logic [31:0] end_s;
    logic [31:0] run_c;
    logic [31:0] gated_c;
    bit          is_to;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        trigger;
  logic        test_undone;
  logic        enable;
  logic [31:0] cycle_count;

  logic        busy, done, done_pulse, timeout;
  logic [31:0] start_stamp, end_stamp, run_cycles, gated_cycles;
  logic [1:0]  state;

  logic        s_busy, s_done, s_done_pulse, s_timeout;
  logic [7:0]  s_start, s_end, s_run, s_gated;
  logic [1:0]  s_state;

  int   total = 0;
  int   bad   = 0;
  exp_t sb[$];

  trackers #(
    .CYCLE_CNT_W    (32),
    .TIMEOUT_CYCLES (T)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .trigger      (trigger),
    .test_undone  (test_undone),
    .enable       (enable),
    .cycle_count  (cycle_count),
    .busy         (busy),
    .done         (done),
    .done_pulse   (done_pulse),
    .timeout      (timeout),
    .start_stamp  (start_stamp),
    .end_stamp    (end_stamp),
    .run_cycles   (run_cycles),
    .gated_cycles (gated_cycles),
    .state        (state)
  );

  trackers #(
    .CYCLE_CNT_W    (8)
  ) dut_small (
    .clk          (clk),
    .rst          (rst),
    .trigger      (trigger),
    .test_undone  (test_undone),
    .enable       (enable),
    .cycle_count  (cycle_count[7:0]),
    .busy         (s_busy),
    .done         (s_done),
    .done_pulse   (s_done_pulse),
    .timeout      (s_timeout),
    .start_stamp  (s_start),
    .end_stamp    (s_end),
    .run_cycles   (s_run),
    .gated_cycles (s_gated),
    .state        (s_state)
  );

  always #5 clk = ~clk;

  // One comparison: bump the totals and report any difference.
  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  // Everything the tracker shows must be zero after reset.
  task automatic checkIdle(input string tag);
    checkOutput({tag, "_state"},      32'(state), 32'd0);
    checkOutput({tag, "_busy"},       32'(busy), 32'd0);
    checkOutput({tag, "_done"},       32'(done), 32'd0);
    checkOutput({tag, "_done_pulse"}, 32'(done_pulse), 32'd0);
    checkOutput({tag, "_timeout"},    32'(timeout), 32'd0);
    checkOutput({tag, "_start"},      start_stamp, 32'd0);
    checkOutput({tag, "_end"},        end_stamp, 32'd0);
    checkOutput({tag, "_run"},        run_cycles, 32'd0);
    checkOutput({tag, "_gated"},      gated_cycles, 32'd0);
  endtask

  // Issue one run: trigger with cycle_count=c0, test_undone first sampled low
  // d clocks after the trigger edge. en_mode: 0 enable high, 1 enable low,
  // 2 low for clocks 10..14, 3 random. mid_trig re-pulses trigger mid-run;
  // reset_at>0 aborts the run with a reset at that clock.
  task automatic applyStimulus(input logic [31:0] c0, input int d, input int en_mode,
                               input int mid_trig, input int reset_at);
    bit   en[1:512];
    int   end_k, runlen, gated;
    exp_t e;
    end_k  = (d < 2) ? 2 : d;
    runlen = (end_k <= T) ? end_k : T;
    gated  = 0;
    for (int j = 1; j <= 512; j++) begin
      case (en_mode)
        0:       en[j] = 1'b1;
        1:       en[j] = 1'b0;
        2:       en[j] = !(j >= 10 && j <= 14);
        default: en[j] = 1'($urandom_range(0, 1));
      endcase
      if (j <= runlen && !en[j]) gated++;
    end
    if (reset_at == 0) begin
      e.start_s = c0;
      e.run_c   = 32'(runlen);
      e.end_s   = c0 + 32'(runlen);
      e.gated_c = 32'(gated);
      e.is_to   = (end_k > T);
      sb.push_back(e);
    end

    @(negedge clk);
    cycle_count = c0;
    trigger     = 1'b1;
    test_undone = 1'b1;
    enable      = 1'b1;
    @(negedge clk);
    trigger = 1'b0;
    checkOutput("busy_after_trigger", 32'(busy), 32'd1);
    for (int j = 1; j <= end_k; j++) begin
      cycle_count = c0 + 32'(j);
      test_undone = (j < d);
      enable      = en[j];
      trigger     = (j == mid_trig);
      if (j == reset_at) begin
        #2 rst = 1'b1;
        #1 checkIdle("midrun_reset");
        @(negedge clk);
        rst     = 1'b0;
        trigger = 1'b0;
        return;
      end
      @(negedge clk);
    end
    trigger     = 1'b0;
    test_undone = 1'b1;
    for (int k = 0; k < 20 && sb.size() > 0; k++) @(negedge clk);
    checkOutput("scoreboard_drain", 32'(sb.size()), 32'd0);
    sb.delete();
  endtask

  // Monitor: a rising done_pulse or timeout marks the end of a run; compare
  // the result against the oldest queued expectation. Also checks the
  // strobe never lasts past its first cycle.
  bit   pulse_prev = 1'b0;
  bit   to_prev    = 1'b0;
  exp_t m;
  always @(negedge clk) begin
    if (rst) begin
      pulse_prev = 1'b0;
      to_prev    = 1'b0;
    end else begin
      if (pulse_prev) checkOutput("done_pulse_width", 32'(done_pulse), 32'd0);
      if (done_pulse || (timeout && !to_prev)) begin
        if (sb.size() == 0) begin
          total++;
          bad++;
          $display("[TB] FAIL unexpected_end actual=run end seen required=no run pending");
        end else begin
          m = sb.pop_front();
          checkOutput("end_state",   32'(state), m.is_to ? 32'd3 : 32'd2);
          checkOutput("end_busy",    32'(busy), 32'd0);
          checkOutput("end_done",    32'(done), m.is_to ? 32'd0 : 32'd1);
          checkOutput("end_timeout", 32'(timeout), m.is_to ? 32'd1 : 32'd0);
          checkOutput("start_stamp", start_stamp, m.start_s);
          checkOutput("end_stamp",   end_stamp, m.end_s);
          checkOutput("run_cycles",  run_cycles, m.run_c);
          checkOutput("gated_cycles", gated_cycles, m.gated_c);
        end
      end
      pulse_prev = done_pulse;
      to_prev    = timeout;
    end
  end

  // Hard stop in case anything above never returns.
  initial begin
    #800000;
    $display("[TB] FAIL watchdog actual=still running required=finished");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int d, mt;
    rst         = 1'b1;
    trigger     = 1'b0;
    test_undone = 1'b1;
    enable      = 1'b1;
    cycle_count = 32'd0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    $display("[TB] checking idle after reset");
    checkIdle("reset");

    applyStimulus(32'd100, 37, 0, 0, 0);
    applyStimulus(32'd100, 37, 2, 0, 0);
    applyStimulus(32'd5000, 60, 0, 0, 0);
    applyStimulus(32'd7, T, 3, 0, 0);
    applyStimulus(32'd7, T + 1, 3, 0, 0);
    applyStimulus(32'd20, 1, 0, 0, 0);
    applyStimulus(32'd20, 2, 1, 0, 0);
    applyStimulus(32'hFFFF_FFF0, 32, 0, 0, 0);
    applyStimulus(32'd400, 30, 0, 12, 0);
    applyStimulus(32'd500, 40, 0, 0, 10);
    applyStimulus(32'd700, 20, 3, 0, 0);

    $display("[TB] checking saturation on the 8-bit instance");
    applyStimulus(32'd1000, 300, 1, 0, 0);
    checkOutput("sat_done",  32'(s_done), 32'd1);
    checkOutput("sat_run",   32'(s_run), 32'hFF);
    checkOutput("sat_gated", 32'(s_gated), 32'hFF);
    checkOutput("sat_start", 32'(s_start), 32'hE8);
    checkOutput("sat_end",   32'(s_end), 32'h14);

    for (int i = 0; i < 25; i++) begin
      d  = $urandom_range(1, 60);
      mt = ($urandom_range(0, 2) == 0 && d > 3 && d <= T) ? $urandom_range(1, d - 1) : 0;
      applyStimulus($urandom, d, $urandom_range(0, 3), mt, 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
